// File: rtl/rle_run_decoder.sv
// rle_run_decoder: buffers run-length words and expands them into a toggling 1-bit symbol stream; RLE_DEC_PIXCNT_EN adds a frame-length check
module rle_run_decoder #(
   parameter int   RUN_W        = 10,
   parameter int   FIFO_DEPTH   = 4,
   parameter logic START_SYM    = 1'b0,
   parameter int   FRAME_PIXELS = 640
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             new_im,
   input  logic             run_valid,
   output logic             run_ready,
   input  logic [RUN_W-1:0] run_len,
   input  logic             run_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sym,
   output logic             out_sof,
   output logic             out_eof,
   output logic             pix_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t           state_q, state_d;
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [RUN_W:0]   mem_q [FIFO_DEPTH];
   logic [RUN_W-1:0] cnt_q, cnt_d, len_q, len_d;
   logic             last_q, last_d, sym_q, sym_d, sof_q, sof_d, nxt_q, nxt_d;
   logic             full, empty, push, pop, acc, run_end, bof;
   logic [RUN_W:0]   head;
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty     = wr_q == rd_q;
   assign run_ready = RST_N && !full && !new_im;
   assign push      = run_valid && run_ready;
   assign head      = mem_q[rd_q[AW-1:0]];
   assign out_valid = state_q == EMIT;
   assign acc       = out_valid && out_ready;
   assign run_end   = acc && (cnt_q == len_q);
   assign out_sym   = sym_q;
   assign out_sof   = out_valid && sof_q;
   assign out_eof   = out_valid && last_q && (cnt_q == len_q);
   // run buffer storage; entries are only read after being written, so no reset
   always_ff @(posedge CLK)
      if (push) mem_q[wr_q[AW-1:0]] <= {run_last, run_len};
   // decoder next state: load a run when idle or at run end, otherwise count accepted symbols
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      last_d  = last_q;
      sym_d   = sym_q;
      sof_d   = sof_q;
      nxt_d   = nxt_q;
      pop     = 1'b0;
      bof     = (state_q == IDLE) ? nxt_q : last_q;
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      if (acc) begin
         cnt_d = cnt_q + 1'b1;
         sof_d = 1'b0;
      end
      if ((state_q == IDLE || run_end) && !empty) begin
         pop     = 1'b1;
         state_d = EMIT;
         cnt_d   = '0;
         len_d   = head[RUN_W-1:0];
         last_d  = head[RUN_W];
         sym_d   = bof ? START_SYM : ~sym_q;
         sof_d   = bof;
         nxt_d   = 1'b0;
      end else if (run_end) begin
         state_d = IDLE;
         cnt_d   = '0;
         nxt_d   = last_q;
      end
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      if (new_im) begin
         state_d = IDLE;
         wr_d    = '0;
         rd_d    = '0;
         cnt_d   = '0;
         sym_d   = START_SYM;
         sof_d   = 1'b0;
         nxt_d   = 1'b1;
      end
   end
   // decoder and buffer pointer registers
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         last_q  <= 1'b0;
         sym_q   <= START_SYM;
         sof_q   <= 1'b0;
         nxt_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         last_q  <= last_d;
         sym_q   <= sym_d;
         sof_q   <= sof_d;
         nxt_q   <= nxt_d;
      end
`ifdef RLE_DEC_PIXCNT_EN
   localparam int PW = $clog2(FRAME_PIXELS + 1) + 1;
   logic [PW-1:0] pc_q, pc_d;
   logic          pix_err_q;
   assign pc_d    = out_sof ? PW'(1) : (&pc_q ? pc_q : pc_q + 1'b1);
   assign pix_err = pix_err_q;
   // per-frame symbol count; flag a frame that ends short or long, or overruns early
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         pc_q      <= '0;
         pix_err_q <= 1'b0;
      end else if (new_im) begin
         pc_q      <= '0;
         pix_err_q <= 1'b0;
      end else if (acc) begin
         pc_q <= pc_d;
         if (pc_d > PW'(FRAME_PIXELS) || (out_eof && pc_d != PW'(FRAME_PIXELS))) pix_err_q <= 1'b1;
      end
`else
   assign pix_err = FRAME_PIXELS < 0;
`endif
endmodule

// File: doc/rle_run_decoder.md
RLE_RUN_DECODER -- requirements
Module: rle_run_decoder

Interface
REQ-001 Parameter RUN_W, default 10, width of one run-length word.
REQ-002 Parameter FIFO_DEPTH, default 4, run-length buffer entries (power of two, >=2).
REQ-003 Parameter START_SYM, default 0, symbol value of the first run of every frame.
REQ-004 Parameter FRAME_PIXELS, default 640, expected symbols per frame (used only under RLE_DEC_PIXCNT_EN).
REQ-005 CLK  input  1  single clock, all state on rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 new_im  input  1  synchronous flush / start of new image.
REQ-008 run_valid  input  1  run_len/run_last valid.
REQ-009 run_ready  output  1  buffer can accept a run.
REQ-010 run_len  input  RUN_W  run length; value L encodes L+1 symbols.
REQ-011 run_last  input  1  run is the final run of the frame.
REQ-012 out_valid  output  1  out_sym valid.
REQ-013 out_ready  input  1  downstream accepts out_sym.
REQ-014 out_sym  output  1  decoded symbol (toggles between runs).
REQ-015 out_sof  output  1  first symbol of a frame.
REQ-016 out_eof  output  1  last symbol of a frame.
REQ-017 pix_err  output  1  frame length mismatch, sticky until new_im (only under RLE_DEC_PIXCNT_EN, else tied 0).

Function
REQ-018 Run accepted when run_valid && run_ready; run_ready = buffer not full.
REQ-019 Buffer is FIFO_DEPTH-entry FIFO of {run_len, run_last}; full and empty tracked with log2(FIFO_DEPTH)+1-bit pointers, wrap-around transparent.
REQ-020 Decoder FSM states: IDLE (no run loaded), EMIT (emitting current run).
REQ-021 IDLE -> EMIT when buffer non-empty: pop head, load run counter to 0, out_valid=1 next cycle.
REQ-022 Latency: run accepted at cycle t into empty buffer with FSM IDLE -> first out_valid at t+2.
REQ-023 In EMIT, output advances only on out_valid && out_ready; out_sym, out_sof, out_eof held stable while stalled.
REQ-024 Run counter (RUN_W bits) increments per accepted symbol; on symbol where counter == run_len, run ends.
REQ-025 At run end with buffer non-empty: pop next run same cycle, toggle out_sym, counter to 0, no bubble.
REQ-026 At run end with buffer empty: EMIT -> IDLE, out_valid=0; next run resumes with toggled symbol.
REQ-027 At end of run with run_last=1: next emitted symbol is START_SYM, out_sof=1 on it.
REQ-028 out_eof=1 exactly on last symbol of a run_last run.
REQ-029 run_len = 2^RUN_W-1 emits 2^RUN_W symbols; counter never wraps.
REQ-030 new_im=1: FIFO emptied, FSM to IDLE, counter 0, out_valid 0, next symbol START_SYM with out_sof, pix_err cleared; run pushes in same cycle discarded; run_ready=0 during new_im.
REQ-031 Simultaneous push and pop on full buffer: pop frees entry, push still blocked that cycle (run_ready depends on registered full only).

Reset
REQ-032 RST_N low asynchronously: FIFO empty, FSM IDLE, counter 0, out_valid 0, out_sym START_SYM, out_sof 0, out_eof 0, pix_err 0, run_ready 0 while RST_N low.
REQ-033 Reset mid-run discards current and buffered runs; first frame after release starts with START_SYM and out_sof.

Configuration
REQ-034 Macro RLE_DEC_PIXCNT_EN defined: per-frame symbol counter (clog2(FRAME_PIXELS+1)+1 bits, saturating) counts accepted symbols; pix_err set at out_eof if count != FRAME_PIXELS, or if count exceeds FRAME_PIXELS before eof.
REQ-035 Macro undefined: no counter logic, pix_err constant 0.

Verification
REQ-036 Runs {2,0,3 last}, out_ready=1 -> out_sym 0,0,0,1,0,0,0,0; sof on 1st, eof on 8th, no bubbles.
REQ-037 Same runs, out_ready low 3 cycles mid-run -> outputs held stable, identical sequence resumes.
REQ-038 Push 5 runs with out_ready=0, FIFO_DEPTH=4 -> run_ready=0 after 4th FIFO entry (1 loaded in FSM), 6th push stalls.
REQ-039 Assert new_im during run 2 of 3 -> out_valid 0 next cycle; new frame {1 last} emits START_SYM twice with sof/eof.
REQ-040 RUN_W=4, run_len=15 last -> exactly 16 symbols, counter no wrap.
REQ-041 RLE_DEC_PIXCNT_EN, FRAME_PIXELS=8, frame totalling 7 symbols -> pix_err=1 at eof, cleared by new_im.
